// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative radix-2 unsigned multiply/divide execute unit placed directly after
// the register file. Every operation takes exactly XLEN iterations, one per
// clock, followed by a single DONE cycle that presents the result together
// with a register-file write strobe.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request a new operation (accepted in IDLE or DONE)
//   op         in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   operand_a  in   multiplicand / dividend (ReadData1)
//   operand_b  in   multiplier / divisor (ReadData2)
//   rd_in      in   destination register index
//   busy       out  high while iterating
//   done       out  one-cycle pulse, result and rd_out valid
//   reg_write  out  copy of done, drives RegWrite
//   result     out  operation result, drives WriteData (held until next DONE)
//   rd_out     out  destination index, drives RD (held until next DONE)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            reg_write,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [1:0]        op_q,     op_d;
  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
  logic [XLEN-1:0]   b_q,      b_d;
  // MUL: {product high, multiplier/product low}. DIV: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q,    acc_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q,     rd_d;

  // ---------------------------------------------------------------------------
  // One shift-add multiply step. The sum is XLEN+1 bits so the carry out of the
  // upper-half add drops into the MSB when the accumulator shifts right.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc = {mul_sum, acc_q[XLEN-1:1]};
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step. The shifted remainder needs XLEN+1 bits since
  // it can reach 2*divisor-1; the subtraction's top bit is the borrow.
  // With a zero divisor no borrow ever occurs, so the quotient fills with ones
  // and the dividend shifts intact into the remainder half, which yields the
  // required divide-by-zero results without a special case.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_acc;

  always_comb begin
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = rem_shift - {1'b0, b_q};
    if (div_diff[XLEN]) begin
      div_acc = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_acc = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  logic [2*XLEN-1:0] iter_acc;
  assign iter_acc = op_q[1] ? div_acc : mul_acc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rd_lat_d = rd_lat_q;
    result_d = result_q;
    rd_d     = rd_q;

    case (state_q)
      S_RUN: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          // op[0] picks the upper half: MULHU (product high) and REMU
          // (remainder); MUL and DIVU take the lower half.
          result_d = op_q[0] ? iter_acc[2*XLEN-1:XLEN] : iter_acc[XLEN-1:0];
          rd_d     = rd_lat_q;
        end
      end

      default: begin
        // IDLE and DONE both accept a new request; start in RUN is ignored.
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          op_d     = op;
          rd_lat_d = rd_in;
          if (op[1]) begin
            b_d   = operand_b;
            acc_d = {{XLEN{1'b0}}, operand_a};
          end else begin
            b_d   = operand_a;
            acc_d = {{XLEN{1'b0}}, operand_b};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rd_lat_q <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rd_lat_q <= rd_lat_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign reg_write = done;
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 64-bit unsigned multiply/divide execute unit that sits directly downstream of the register file. It consumes the register file's two read operands (ReadData1 as operand_a, ReadData2 as operand_b) and a destination index. It produces a result, a destination index and a one-cycle write strobe that drive the register file's WriteData, RD and RegWrite inputs. Radix-2 multi-cycle implementation with a fixed latency and a start/busy/done handshake.

Parameters:
XLEN, 64, operand and result width in bits.
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  request a new operation; sampled on posedge.
op  input  2  operation: 00 MUL (low XLEN of product), 01 MULHU (high XLEN of product), 10 DIVU (quotient), 11 REMU (remainder).
operand_a  input  XLEN  multiplicand / dividend (from ReadData1).
operand_b  input  XLEN  multiplier / divisor (from ReadData2).
rd_in  input  5  destination register index.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result and rd_out are valid.
reg_write  output  1  equals done; drives the register file's RegWrite.
result  output  XLEN  operation result; drives the register file's WriteData.
rd_out  output  5  latched rd_in; drives the register file's RD.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy=0, done=0, reg_write=0, result=0, rd_out=0; counter and internal accumulators cleared. Applies immediately, including mid-operation; the in-flight operation is discarded and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- Acceptance: start==1 at a posedge while in IDLE or DONE.
  - Latches op, operand_a, operand_b and rd_in; counter=0; next state RUN.
  - Input changes after acceptance have no effect.
- start while in RUN is ignored; no queuing.
- RUN: one iteration per cycle, exactly XLEN iterations; counter increments each cycle. After the XLEN-th iteration the next state is DONE.
- MUL/MULHU: 2*XLEN-bit shift-add.
  - Each iteration examines the multiplier LSB; if 1, the multiplicand is added into the upper half of the accumulator (carry kept).
  - The accumulator then shifts right by 1.
  - MUL returns acc[XLEN-1:0]; MULHU returns acc[2*XLEN-1:XLEN].
- DIVU/REMU: restoring division.
  - Each iteration shifts {remainder, quotient} left by 1, then trial-subtracts the divisor from the remainder.
  - If there is no borrow, keep the difference and set quotient bit 0 to 1.
- Divide by zero (operand_b==0): DIVU result = all ones (2^XLEN-1); REMU result = operand_a. Latency is unchanged (no early exit).
- DONE: lasts exactly one cycle. done=1, reg_write=1, result and rd_out valid.
  - Next state is RUN if start==1, else IDLE.
- busy: 1 in RUN, 0 in IDLE and DONE.
- Latency: accept at posedge N; busy high from N to N+XLEN; done high for the cycle between posedges N+XLEN and N+XLEN+1 (XLEN+1 edges from accept to done falling).
- result and rd_out hold their values after done until the next DONE or reset. They are updated only on entry to DONE.
- Back-to-back: start asserted during DONE is accepted. The done pulse of the previous operation still completes in that cycle.
- Arithmetic is unsigned only; no signed ops. Nothing writes register x0 specially; rd_out is passed through unmodified.

Test Plan:
- Reset: reset=0 mid-RUN (20 cycles after start of MUL 7*6), released, then 70 cycles idle -> busy=0, done never pulses, result=0, rd_out=0.
- MUL 7*6, rd_in=20 -> busy for 64 cycles, then one-cycle done/reg_write with result=42 and rd_out=20; result holds 42 afterwards.
- MUL/MULHU 0xFFFF_FFFF_FFFF_FFFF * 2 -> MUL result=0xFFFF_FFFF_FFFF_FFFE; MULHU result=1.
- DIVU/REMU 100/7 -> 14 and 2. DIVU/REMU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF and 5, both with unchanged 64-cycle latency.
- start pulsed at cycle 10 of a running DIVU, with different operands -> ignored; original quotient is returned and exactly one done pulse occurs.
- Back-to-back: start held high with MUL 3*5 then, in the DONE cycle, DIVU 9/2 -> done with 15, then after a further 64 cycles done with 4, and no IDLE cycle between the two operations.
